// File: rtl/rv_hazard_pkg.sv
// Shared constants and FSM state type for the RV32I pipeline hazard controller.
package rv_hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        LU_STALL,
        MEM_WAIT
    } hz_state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard controller bundle: stage register addresses and controls in,
// stall/flush enables and E-stage forwarding selects out.
interface hazard_unit_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] rs1_d, rs2_d;
    logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;
    logic [REG_AW-1:0] rd_m, rd_w;
    logic              reg_write_e, reg_write_m, reg_write_w;
    logic [1:0]        result_src_e;
    logic              pc_src_e;
    logic              dmem_req_m, dmem_ready_m;
    logic              stall_f, stall_d, stall_e, stall_m;
    logic              flush_d, flush_e, flush_w;
    logic [1:0]        forward_a_e, forward_b_e;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        output reg_write_e, reg_write_m, reg_write_w, result_src_e,
        output pc_src_e, dmem_req_m, dmem_ready_m,
        input  stall_f, stall_d, stall_e, stall_m,
        input  flush_d, flush_e, flush_w, forward_a_e, forward_b_e
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
        input  reg_write_e, reg_write_m, reg_write_w, result_src_e,
        input  pc_src_e, dmem_req_m, dmem_ready_m,
        output stall_f, stall_d, stall_e, stall_m,
        output flush_d, flush_e, flush_w, forward_a_e, forward_b_e
    );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Single-operand producer comparator: picks the nearer writing stage whose nonzero
// destination matches the source register (x0 never matches).
module hazard_fwd_sel
    import rv_hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic [REG_AW-1:0] i_rd_near,
    input  logic              i_we_near,
    input  logic [REG_AW-1:0] i_rd_far,
    input  logic              i_we_far,
    output logic [1:0]        o_fwd
);
    logic w_hit_near, w_hit_far;

    assign w_hit_near = i_we_near && (i_rd_near != '0) && (i_rd_near == i_rs);
    assign w_hit_far  = i_we_far  && (i_rd_far  != '0) && (i_rd_far  == i_rs);

    always_comb begin
        o_fwd = FWD_RF;
        if (w_hit_near) begin
            o_fwd = FWD_MEM;
        end else if (w_hit_far) begin
            o_fwd = FWD_WB;
        end
    end
endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: load-use stall sequencing, data-memory wait and branch flush.
// Macro HAZARD_FWD_EN enables E-stage forwarding; otherwise D-stage RAW hazards stall.
module hazard_unit
    import rv_hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1
) (
    input logic         clk,
    input logic         rst,
    hazard_unit_if.slave bus
);
    localparam int LU_W = $clog2(LOAD_LAT + 1);

    hz_state_t         r_state, w_state_next, w_eff_state;
    logic [LU_W-1:0]   r_lu_cnt, w_lu_cnt_next;
    logic              w_mw, w_lu_hit, w_raw_hit;
    logic              w_stall_f, w_stall_d, w_stall_e, w_stall_m;
    logic              w_flush_d, w_flush_e, w_flush_w;
    logic [1:0]        w_fwd_a, w_fwd_b;
    logic              w_unused_cfg;

    // The comparator pair serves as forwarding select or, without forwarding, as the
    // D-stage RAW detector against the E (near) and M (far) destinations.
    logic [REG_AW-1:0] w_cmp_rs [2];
    logic [REG_AW-1:0] w_cmp_rd_near, w_cmp_rd_far;
    logic              w_cmp_we_near, w_cmp_we_far;
    logic [1:0]        w_cmp [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
        hazard_fwd_sel #(.REG_AW(REG_AW)) u_sel (
            .i_rs      (w_cmp_rs[gi]),
            .i_rd_near (w_cmp_rd_near),
            .i_we_near (w_cmp_we_near),
            .i_rd_far  (w_cmp_rd_far),
            .i_we_far  (w_cmp_we_far),
            .o_fwd     (w_cmp[gi])
        );
    end

`ifdef HAZARD_FWD_EN
    assign w_cmp_rs[0]   = bus.rs1_e;
    assign w_cmp_rs[1]   = bus.rs2_e;
    assign w_cmp_rd_near = bus.rd_m;
    assign w_cmp_we_near = bus.reg_write_m;
    assign w_cmp_rd_far  = bus.rd_w;
    assign w_cmp_we_far  = bus.reg_write_w;
    assign w_fwd_a       = w_cmp[0];
    assign w_fwd_b       = w_cmp[1];
    assign w_raw_hit     = 1'b0;
    assign w_unused_cfg  = bus.reg_write_e;
`else
    assign w_cmp_rs[0]   = bus.rs1_d;
    assign w_cmp_rs[1]   = bus.rs2_d;
    assign w_cmp_rd_near = bus.rd_e;
    assign w_cmp_we_near = bus.reg_write_e;
    assign w_cmp_rd_far  = bus.rd_m;
    assign w_cmp_we_far  = bus.reg_write_m;
    assign w_fwd_a       = FWD_RF;
    assign w_fwd_b       = FWD_RF;
    assign w_raw_hit     = |{w_cmp[0], w_cmp[1]};
    assign w_unused_cfg  = &{1'b0, bus.rs1_e, bus.rs2_e, bus.rd_w, bus.reg_write_w};
`endif

    assign w_mw     = bus.dmem_req_m & ~bus.dmem_ready_m;
    assign w_lu_hit = (bus.result_src_e == RESULT_SRC_LOAD) && (bus.rd_e != '0) &&
                      ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d));

    // A MEM_WAIT cycle whose ready has arrived already behaves as the state it resumes,
    // so the frozen load-use count and any held redirect take effect without a gap.
    always_comb begin
        w_eff_state = r_state;
        if (r_state == MEM_WAIT && !w_mw) begin
            w_eff_state = (r_lu_cnt != '0) ? LU_STALL : IDLE;
        end
    end

    always_comb begin
        w_state_next  = w_eff_state;
        w_lu_cnt_next = r_lu_cnt;
        w_stall_f     = 1'b0;
        w_stall_d     = 1'b0;
        w_stall_e     = 1'b0;
        w_stall_m     = 1'b0;
        w_flush_d     = 1'b0;
        w_flush_e     = 1'b0;
        w_flush_w     = 1'b0;
        if (w_mw) begin
            {w_stall_f, w_stall_d, w_stall_e, w_stall_m, w_flush_w} = '1;
            w_state_next = MEM_WAIT;
        end else begin
            case (w_eff_state)
                LU_STALL: begin
                    {w_stall_f, w_stall_d, w_flush_e} = '1;
                    w_lu_cnt_next = r_lu_cnt - LU_W'(1);
                    if (r_lu_cnt == LU_W'(1)) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    if (w_lu_hit) begin
                        {w_stall_f, w_stall_d, w_flush_e} = '1;
                        if (LOAD_LAT > 1) begin
                            w_lu_cnt_next = LU_W'(LOAD_LAT - 1);
                            w_state_next  = LU_STALL;
                        end
                    end
                    if (bus.pc_src_e) begin
                        w_flush_d = 1'b1;
                        w_flush_e = 1'b1;
                    end
                end
            endcase
            if (w_raw_hit) begin
                {w_stall_f, w_stall_d, w_flush_e} = '1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_lu_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_lu_cnt <= w_lu_cnt_next;
        end
    end

    assign bus.stall_f     = w_stall_f & ~rst;
    assign bus.stall_d     = w_stall_d & ~rst;
    assign bus.stall_e     = w_stall_e & ~rst;
    assign bus.stall_m     = w_stall_m & ~rst;
    assign bus.flush_d     = w_flush_d & ~rst;
    assign bus.flush_e     = w_flush_e & ~rst;
    assign bus.flush_w     = w_flush_w & ~rst;
    assign bus.forward_a_e = w_fwd_a & {2{~rst}};
    assign bus.forward_b_e = w_fwd_b & {2{~rst}};
endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, hand-written multi-cycle
// sequences and random traffic, all against an owed-bubble reference model.
module tb_hazard_unit;
    import rv_hazard_pkg::*;

    typedef struct packed {
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic       we_e, we_m, we_w;
        logic [1:0] rsrc;
        logic       pc, req, rdy;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [6:0] ctl;   // {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_w}
        logic [3:0] fwd;   // {forward_a_e,forward_b_e} with forwarding enabled
        logic       raw;   // D-stage RAW stall expected without forwarding
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_unit_if #(.REG_AW(5)) bus1 ();
    hazard_unit_if #(.REG_AW(5)) bus3 ();

    hazard_unit #(.REG_AW(5), .LOAD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    hazard_unit #(.REG_AW(5), .LOAD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    logic [10:0] out1, out3;
    assign out1 = {bus1.stall_f, bus1.stall_d, bus1.stall_e, bus1.stall_m, bus1.flush_d,
                   bus1.flush_e, bus1.flush_w, bus1.forward_a_e, bus1.forward_b_e};
    assign out3 = {bus3.stall_f, bus3.stall_d, bus3.stall_e, bus3.stall_m, bus3.flush_d,
                   bus3.flush_e, bus3.flush_w, bus3.forward_a_e, bus3.forward_b_e};

    in_t  cur;
    int   lu_left1 = 0, lu_left3 = 0;   // load-use bubbles still owed after this cycle
    int   n_pass = 0, n_total = 0;
    vec_t tbl[$];

    function automatic in_t quiet();
        in_t v;
        v = '0;
        v.rdy = 1'b1;
        return v;
    endfunction

`ifdef HAZARD_FWD_EN
    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input in_t v);
        if (v.we_m && v.rd_m != 0 && v.rd_m == rs) return 2'b10;
        if (v.we_w && v.rd_w != 0 && v.rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction
`endif

    function automatic logic [10:0] model_out(input in_t v, input int left, input int lat,
                                              input logic r, output int left_next);
        logic sf, sd, se, sm, fd, fe, fw, mw, lu;
        logic [1:0] fa, fb;
        {sf, sd, se, sm, fd, fe, fw} = '0;
        fa = 2'b00;
        fb = 2'b00;
        left_next = left;
        if (r) begin
            left_next = 0;
            return '0;
        end
        mw = v.req && !v.rdy;
        lu = (v.rsrc == 2'b01) && v.rd_e != 0 && (v.rd_e == v.rs1_d || v.rd_e == v.rs2_d);
        if (mw) begin
            {sf, sd, se, sm, fw} = '1;
        end else if (left > 0) begin
            {sf, sd, fe} = '1;
            left_next = left - 1;
        end else begin
            if (lu) begin
                {sf, sd, fe} = '1;
                left_next = lat - 1;
            end
            if (v.pc) {fd, fe} = '1;
        end
`ifdef HAZARD_FWD_EN
        fa = ref_fwd(v.rs1_e, v);
        fb = ref_fwd(v.rs2_e, v);
`else
        if (!mw && ((v.we_e && v.rd_e != 0 && (v.rd_e == v.rs1_d || v.rd_e == v.rs2_d)) ||
                    (v.we_m && v.rd_m != 0 && (v.rd_m == v.rs1_d || v.rd_m == v.rs2_d))))
            {sf, sd, fe} = '1;
`endif
        return {sf, sd, se, sm, fd, fe, fw, fa, fb};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic apply();
        {bus1.rs1_d, bus1.rs2_d, bus1.rs1_e, bus1.rs2_e} = {cur.rs1_d, cur.rs2_d, cur.rs1_e, cur.rs2_e};
        {bus3.rs1_d, bus3.rs2_d, bus3.rs1_e, bus3.rs2_e} = {cur.rs1_d, cur.rs2_d, cur.rs1_e, cur.rs2_e};
        {bus1.rd_e, bus1.rd_m, bus1.rd_w} = {cur.rd_e, cur.rd_m, cur.rd_w};
        {bus3.rd_e, bus3.rd_m, bus3.rd_w} = {cur.rd_e, cur.rd_m, cur.rd_w};
        {bus1.reg_write_e, bus1.reg_write_m, bus1.reg_write_w} = {cur.we_e, cur.we_m, cur.we_w};
        {bus3.reg_write_e, bus3.reg_write_m, bus3.reg_write_w} = {cur.we_e, cur.we_m, cur.we_w};
        bus1.result_src_e = cur.rsrc;
        bus3.result_src_e = cur.rsrc;
        {bus1.pc_src_e, bus1.dmem_req_m, bus1.dmem_ready_m} = {cur.pc, cur.req, cur.rdy};
        {bus3.pc_src_e, bus3.dmem_req_m, bus3.dmem_ready_m} = {cur.pc, cur.req, cur.rdy};
    endtask

    // One clock: drive, compare both latencies at the falling edge, advance the model.
    task automatic step(input string name);
        logic [10:0] e1, e3;
        int n1, n3;
        apply();
        @(negedge clk);
        e1 = model_out(cur, lu_left1, 1, rst, n1);
        e3 = model_out(cur, lu_left3, 3, rst, n3);
        check({name, "/L1"}, out1, e1);
        check({name, "/L3"}, out3, e3);
        @(posedge clk);
        lu_left1 = n1;
        lu_left3 = n3;
        #1;
    endtask

    task automatic add(input string name, input in_t v, input logic [6:0] ctl,
                       input logic [3:0] fwd, input logic raw);
        vec_t t;
        t.name = name; t.in = v; t.ctl = ctl; t.fwd = fwd; t.raw = raw;
        tbl.push_back(t);
    endtask

    initial begin
        in_t v;
        logic [10:0] exp;

        // Reset held with noisy inputs: every output must stay low.
        rst = 1'b1;
        cur = quiet();
        cur.req = 1'b1; cur.rdy = 1'b0; cur.pc = 1'b1;
        cur.rd_m = 5'd3; cur.we_m = 1'b1; cur.rs1_e = 5'd3;
        #1;
        step("reset_hold");
        rst = 1'b0;

        v = quiet();                                             add("idle", v, 7'b0, 4'b0000, 1'b0);
        v = quiet(); v.rd_m = 7; v.rd_w = 7; v.we_m = 1; v.we_w = 1; v.rs2_e = 7;
                                                                 add("fwd_b_mem", v, 7'b0, 4'b0010, 1'b0);
        v.rd_m = 0;                                              add("fwd_b_wb", v, 7'b0, 4'b0001, 1'b0);
        v.rd_w = 0; v.rs2_e = 0;                                 add("fwd_b_x0", v, 7'b0, 4'b0000, 1'b0);
        v = quiet(); v.rd_m = 3; v.rd_w = 3; v.we_m = 1; v.we_w = 1; v.rs1_e = 3; v.rs2_e = 4;
                                                                 add("fwd_a_m_over_w", v, 7'b0, 4'b1000, 1'b0);
        v.we_m = 0; v.we_w = 0;                                  add("fwd_no_write", v, 7'b0, 4'b0000, 1'b0);
        v = quiet(); v.pc = 1;                                   add("pc_redirect", v, 7'b0000110, 4'b0000, 1'b0);
        v = quiet(); v.req = 1; v.rdy = 0;                       add("mw_stall", v, 7'b1111001, 4'b0000, 1'b0);
        v = quiet(); v.req = 1; v.rdy = 1;                       add("mw_ready_now", v, 7'b0, 4'b0000, 1'b0);
        v = quiet(); v.we_e = 1; v.rd_e = 9; v.rs2_d = 9;        add("raw_e", v, 7'b0, 4'b0000, 1'b1);
        v = quiet(); v.we_m = 1; v.rd_m = 6; v.rs1_d = 6;        add("raw_m", v, 7'b0, 4'b0000, 1'b1);
        v = quiet(); v.we_m = 1;                                 add("raw_m_x0", v, 7'b0, 4'b0000, 1'b0);
        v = quiet(); v.rsrc = 2'b01; v.we_e = 1;                 add("load_x0", v, 7'b0, 4'b0000, 1'b0);

        foreach (tbl[i]) begin
            cur = tbl[i].in;
            apply();
            @(negedge clk);
`ifdef HAZARD_FWD_EN
            exp = {tbl[i].ctl, tbl[i].fwd};
`else
            exp = {tbl[i].ctl | (tbl[i].raw ? 7'b1100010 : 7'b0), 4'b0000};
`endif
            check({tbl[i].name, "/L1"}, out1, exp);
            check({tbl[i].name, "/L3"}, out3, exp);
            @(posedge clk);
            #1;
        end

        // Load x5 in E with rs1_d=5, then the load drains through M and W.
        cur = quiet(); cur.rsrc = 2'b01; cur.rd_e = 5; cur.we_e = 1; cur.rs1_d = 5;
        step("lu_detect");
        cur = quiet(); cur.rd_m = 5; cur.we_m = 1;               step("lu_c1");
        cur = quiet(); cur.rd_w = 5; cur.we_w = 1; cur.rs1_e = 5; step("lu_c2_fwd_w");
        cur = quiet();                                           step("lu_c3");
        step("lu_idle");

        // Memory wait for four cycles inside the load-use stall, then the stall resumes.
        cur = quiet(); cur.rsrc = 2'b01; cur.rd_e = 5; cur.we_e = 1; cur.rs2_d = 5;
        step("lumw_detect");
        cur = quiet(); cur.req = 1; cur.rdy = 0;
        for (int i = 0; i < 4; i++) step("lumw_wait");
        cur = quiet();
        for (int i = 0; i < 3; i++) step("lumw_resume");

        // Redirect held across a two-cycle wait is flushed in the first ready cycle.
        cur = quiet(); cur.pc = 1; cur.req = 1; cur.rdy = 0;
        step("pcmw_wait0");
        step("pcmw_wait1");
        cur.rdy = 1;                                             step("pcmw_ready");
        cur = quiet();                                           step("pcmw_after");

        // Load-use and redirect together.
        cur = quiet(); cur.rsrc = 2'b01; cur.rd_e = 4; cur.we_e = 1; cur.rs2_d = 4; cur.pc = 1;
        step("lupc_detect");
        cur = quiet();
        for (int i = 0; i < 3; i++) step("lupc_tail");

        // Asynchronous reset in the middle of the load-use stall.
        cur = quiet(); cur.rsrc = 2'b01; cur.rd_e = 5; cur.we_e = 1; cur.rs1_d = 5;
        step("rst_lu_detect");
        cur = quiet();
        step("rst_lu_stall");
        #2 rst = 1'b1;
        #1;
        check("rst_async/L1", out1, 11'b0);
        check("rst_async/L3", out3, 11'b0);
        lu_left1 = 0;
        lu_left3 = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        step("post_rst_0");
        step("post_rst_1");

        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            cur.rs1_d = 5'($urandom_range(0, 3));
            cur.rs2_d = 5'($urandom_range(0, 3));
            cur.rs1_e = 5'($urandom_range(0, 3));
            cur.rs2_e = 5'($urandom_range(0, 3));
            cur.rd_e  = 5'($urandom_range(0, 3));
            cur.rd_m  = 5'($urandom_range(0, 3));
            cur.rd_w  = 5'($urandom_range(0, 3));
            cur.we_e  = 1'($urandom_range(0, 1));
            cur.we_m  = 1'($urandom_range(0, 1));
            cur.we_w  = 1'($urandom_range(0, 1));
            cur.rsrc  = 2'($urandom_range(0, 3));
            cur.pc    = ($urandom_range(0, 7) == 0);
            cur.req   = ($urandom_range(0, 3) == 0);
            cur.rdy   = 1'($urandom_range(0, 1));
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
